// File: rtl/dmem_pkg.sv
// Shared types and helpers for the sweep-cleared data memory.
// Parity storage is enabled by defining DMEM_PARITY_EN.
package dmem_pkg;

  typedef enum logic {
    DMEM_SWEEP = 1'b0,
    DMEM_IDLE  = 1'b1
  } dmem_state_e;

  localparam int DMEM_PAR_MAX_W = 64;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic dmem_par(
    input logic [DMEM_PAR_MAX_W-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/dmem_sweep_ctl.sv
// Sweep FSM: walks the array once after reset or clr,
// emitting one init write per cycle.
module dmem_sweep_ctl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] sa,
  output logic              swe
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  dmem_state_e      state, state_n;
  logic [ADDR_W-1:0] sa_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DMEM_SWEEP;
      sa    <= '0;
    end else begin
      state <= state_n;
      sa    <= sa_n;
    end
  end

  always_comb begin
    state_n  = state;
    sa_n     = sa;
    busy     = 1'b0;
    clr_done = 1'b0;
    swe      = 1'b0;
    unique case (state)
      DMEM_SWEEP: begin
        busy = 1'b1;
        swe  = 1'b1;
        if (sa == LAST) begin
          clr_done = 1'b1;
          state_n  = DMEM_IDLE;
          sa_n     = '0;
        end else begin
          sa_n = sa + 1'b1;
        end
      end
      DMEM_IDLE: begin
        if (clr) begin
          state_n = DMEM_SWEEP;
          sa_n    = '0;
        end
      end
      default: state_n = DMEM_SWEEP;
    endcase
  end

endmodule

// File: rtl/dmem_sweep_ram.sv
// Data memory: 1W/2R registered reads with write-through,
// sequential clear sweep, optional parity (DMEM_PARITY_EN).
module dmem_sweep_ram
  import dmem_pkg::*;
#(
  parameter int                DATA_W   = 9,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1,
  output logic              busy,
  output logic              clr_done,
  output logic              perr0,
  output logic              perr1
);

`ifdef DMEM_PARITY_EN
  localparam int WW = DATA_W + 1;
`else
  localparam int WW = DATA_W;
`endif

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [WW-1:0]     mem [DEPTH];
  logic [ADDR_W-1:0] sa;
  logic              swe;
  logic              uw;
  logic              mwe;
  logic [ADDR_W-1:0] mwa;
  logic [WW-1:0]     mwd;
  logic [ADDR_W-1:0] ra [2];

  dmem_sweep_ctl #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ctl (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .busy     (busy),
    .clr_done (clr_done),
    .sa       (sa),
    .swe      (swe)
  );

`ifdef DMEM_PARITY_EN
  function automatic logic [WW-1:0] mk_word(
    input logic [DATA_W-1:0] d
  );
    logic [DMEM_PAR_MAX_W-1:0] x;
    x = '0;
    x[DATA_W-1:0] = d;
    return {dmem_par(x), d};
  endfunction
`else
  function automatic logic [WW-1:0] mk_word(
    input logic [DATA_W-1:0] d
  );
    return d;
  endfunction
`endif

  // A clr in the same cycle wins over a user write.
  assign uw  = !busy && !clr && we && ({1'b0, wa} < DEPTH_X);
  assign mwe = swe | uw;
  assign mwa = swe ? sa : wa;
  assign mwd = swe ? mk_word(INIT_VAL) : mk_word(wd);

  always_ff @(posedge clk) begin
    if (mwe) mem[mwa] <= mwd;
  end

  assign ra[0] = ra0;
  assign ra[1] = ra1;

  for (genvar i = 0; i < 2; i++) begin : g_rd
    logic [WW-1:0]     w;
    logic [DATA_W-1:0] dn;
    logic              pn;
    logic [DATA_W-1:0] rd_q;
    logic              pe_q;

    assign w = mem[ra[i]];

    always_comb begin
      dn = '0;
      pn = 1'b0;
      if (busy) begin
        dn = INIT_VAL;
      end else if ({1'b0, ra[i]} >= DEPTH_X) begin
        dn = '0;
      end else if (uw && ra[i] == wa) begin
        dn = wd;
      end else begin
        dn = w[DATA_W-1:0];
`ifdef DMEM_PARITY_EN
        pn = ^w;
`endif
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_q <= '0;
        pe_q <= 1'b0;
      end else begin
        rd_q <= dn;
        pe_q <= pn;
      end
    end
  end

  assign rd0 = g_rd[0].rd_q;
  assign rd1 = g_rd[1].rd_q;

`ifdef DMEM_PARITY_EN
  assign perr0 = g_rd[0].pe_q;
  assign perr1 = g_rd[1].pe_q;
`else
  assign perr0 = 1'b0;
  assign perr1 = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_sweep_ram.sv
// Scoreboard bench for dmem_sweep_ram: a 256-deep and a
// 200-deep instance share stimulus and are checked together.
module tb_dmem_sweep_ram;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       we  = 1'b0;
  logic [7:0] wa  = '0;
  logic [8:0] wd  = '0;
  logic [7:0] ra0 = '0;
  logic [7:0] ra1 = '0;

  logic [8:0] rd0, rd1, rd0_b, rd1_b;
  logic       busy, clr_done, perr0, perr1;
  logic       busy_b, clr_done_b, perr0_b, perr1_b;

  int vecs = 0;
  int errs = 0;

  logic [8:0] m256 [256];
  logic [8:0] m200 [256];

  typedef struct {
    logic [8:0] a0, a1, b0, b1;
    logic       pe;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  dmem_sweep_ram #(
    .DATA_W(9), .ADDR_W(8), .DEPTH(256), .INIT_VAL(9'h000)
  ) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .wa(wa), .wd(wd),
    .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1), .busy(busy),
    .clr_done(clr_done), .perr0(perr0), .perr1(perr1)
  );

  dmem_sweep_ram #(
    .DATA_W(9), .ADDR_W(8), .DEPTH(200), .INIT_VAL(9'h000)
  ) u_d200 (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .wa(wa), .wd(wd),
    .ra0(ra0), .ra1(ra1), .rd0(rd0_b), .rd1(rd1_b), .busy(busy_b),
    .clr_done(clr_done_b), .perr0(perr0_b), .perr1(perr1_b)
  );

  function automatic logic [8:0] xr(
    input int dep, input logic [7:0] a, input logic w,
    input logic [7:0] wad, input logic [8:0] wdat,
    input logic [8:0] m
  );
    if (int'(a) >= dep) return 9'h000;
    if (w && a == wad) return wdat;
    return m;
  endfunction

  // One IDLE-mode cycle: drive, predict, clock, compare.
  task automatic step(
    input logic iwe, input logic [7:0] iwa, input logic [8:0] iwd,
    input logic [7:0] a0, input logic [7:0] a1, input logic iclr,
    input logic pe, input string nm
  );
    exp_t e;
    logic w;
    w = iwe && !iclr;
    we = iwe; wa = iwa; wd = iwd; ra0 = a0; ra1 = a1; clr = iclr;
    e.a0 = xr(256, a0, w, iwa, iwd, m256[a0]);
    e.a1 = xr(256, a1, w, iwa, iwd, m256[a1]);
    e.b0 = xr(200, a0, w, iwa, iwd, m200[a0]);
    e.b1 = xr(200, a1, w, iwa, iwd, m200[a1]);
    e.pe = pe;
    q.push_back(e);
    @(posedge clk);
    if (w) begin
      m256[iwa] = iwd;
      if (iwa < 8'd200) m200[iwa] = iwd;
    end
    @(negedge clk);
    we = 1'b0; clr = 1'b0;
    e = q.pop_front();
    vecs++;
    if (rd0 !== e.a0) begin
      errs++;
      $display("FAIL %s rd0: got %h want %h", nm, rd0, e.a0);
    end
    vecs++;
    if (rd1 !== e.a1) begin
      errs++;
      $display("FAIL %s rd1: got %h want %h", nm, rd1, e.a1);
    end
    vecs++;
    if (rd0_b !== e.b0) begin
      errs++;
      $display("FAIL %s d200 rd0: got %h want %h", nm, rd0_b, e.b0);
    end
    vecs++;
    if (rd1_b !== e.b1) begin
      errs++;
      $display("FAIL %s d200 rd1: got %h want %h", nm, rd1_b, e.b1);
    end
    vecs++;
    if ({perr0, perr1, perr0_b, perr1_b} !== {e.pe, 3'b000}) begin
      errs++;
      $display("FAIL %s perr: got %b%b%b%b want %b000", nm,
               perr0, perr1, perr0_b, perr1_b, e.pe);
    end
  endtask

  // Count busy / clr_done from the first sweep sample onward.
  task automatic sweep_wait(input string nm, input bit hammer);
    int n256, n200, d256, d200, at256;
    n256 = 0; n200 = 0; d256 = 0; d200 = 0; at256 = -1;
    for (int i = 0; i < 400; i++) begin
      if (busy) begin
        n256++;
        if (i > 0) begin
          vecs++;
          if (rd0 !== 9'h000) begin
            errs++;
            $display("FAIL %s sweep rd0: got %h want 000", nm, rd0);
          end
        end
      end
      if (busy_b) n200++;
      if (clr_done) begin d256++; at256 = i; end
      if (clr_done_b) d200++;
      if (!busy && !busy_b) break;
      if (hammer && busy_b) begin
        we = 1'b1; wa = 8'd3; wd = 9'h111;
      end else begin
        we = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    we = 1'b0;
    vecs++;
    if (n256 != 256) begin
      errs++;
      $display("FAIL %s busy256: got %0d cycles want 256", nm, n256);
    end
    vecs++;
    if (n200 != 200) begin
      errs++;
      $display("FAIL %s busy200: got %0d cycles want 200", nm, n200);
    end
    vecs++;
    if (d256 != 1 || at256 != 255) begin
      errs++;
      $display("FAIL %s clr_done256: got %0d pulses at %0d want 1 at 255",
               nm, d256, at256);
    end
    vecs++;
    if (d200 != 1) begin
      errs++;
      $display("FAIL %s clr_done200: got %0d pulses want 1", nm, d200);
    end
    for (int k = 0; k < 256; k++) begin
      m256[k] = 9'h000;
      m200[k] = 9'h000;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vecs++;
    if ({busy, clr_done, rd0, rd1, perr0, perr1} !== {2'b10, 18'h0, 2'b00}) begin
      errs++;
      $display("FAIL reset: got busy=%b done=%b rd0=%h rd1=%h want 1 0 000 000",
               busy, clr_done, rd0, rd1);
    end
    rst = 1'b0;
    sweep_wait("reset", 1'b0);
    step(1'b0, 8'd0, 9'h0, 8'd0, 8'd100, 1'b0, 1'b0, "init_0_100");
    step(1'b0, 8'd0, 9'h0, 8'd255, 8'd199, 1'b0, 1'b0, "init_255");
  endtask

  task automatic test_write_read();
    step(1'b1, 8'd7, 9'h1A5, 8'd0, 8'd7, 1'b0, 1'b0, "bypass_ra1");
    step(1'b0, 8'd0, 9'h0, 8'd7, 8'd6, 1'b0, 1'b0, "read_back");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), a, 9'($urandom),
           (i % 3 == 0) ? a : 8'($urandom_range(0, 15)),
           8'($urandom_range(0, 15)), 1'b0, 1'b0, "b2b");
    end
  endtask

  task automatic test_clr();
    step(1'b1, 8'd3, 9'h0FF, 8'd3, 8'd0, 1'b0, 1'b0, "pre_clr_wr");
    step(1'b0, 8'd0, 9'h0, 8'd3, 8'd7, 1'b1, 1'b0, "clr_pulse");
    sweep_wait("clr", 1'b1);
    step(1'b0, 8'd0, 9'h0, 8'd3, 8'd7, 1'b0, 1'b0, "post_clr");
  endtask

  task automatic test_depth();
    step(1'b1, 8'd210, 9'h0AB, 8'd210, 8'd0, 1'b0, 1'b0, "oob_bypass");
    step(1'b1, 8'd199, 9'h155, 8'd210, 8'd199, 1'b0, 1'b0, "oob_read");
    step(1'b0, 8'd0, 9'h0, 8'd199, 8'd210, 1'b0, 1'b0, "last_word");
  endtask

  task automatic test_rst_mid();
    step(1'b1, 8'd9, 9'h0C3, 8'd9, 8'd9, 1'b0, 1'b0, "pre_rst_wr");
    step(1'b0, 8'd0, 9'h0, 8'd9, 8'd9, 1'b1, 1'b0, "clr_pulse2");
    repeat (120) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    vecs++;
    if ({busy, rd0} !== {1'b1, 9'h000}) begin
      errs++;
      $display("FAIL rst_mid: got busy=%b rd0=%h want 1 000", busy, rd0);
    end
    @(negedge clk);
    rst = 1'b0;
    sweep_wait("rst_mid", 1'b0);
    step(1'b0, 8'd0, 9'h0, 8'd9, 8'd7, 1'b0, 1'b0, "post_rst");
  endtask

`ifdef DMEM_PARITY_EN
  task automatic test_parity();
    step(1'b1, 8'd5, 9'h0AA, 8'd0, 8'd0, 1'b0, 1'b0, "par_wr");
    u_dut.mem[5][0] = ~u_dut.mem[5][0];
    m256[5] = m256[5] ^ 9'h001;
    step(1'b0, 8'd0, 9'h0, 8'd5, 8'd6, 1'b0, 1'b1, "par_flip");
    m256[5] = 9'h0AA;
    m200[5] = 9'h0AA;
    step(1'b1, 8'd5, 9'h0AA, 8'd6, 8'd5, 1'b0, 1'b0, "par_fix");
  endtask
`endif

  initial begin
    for (int k = 0; k < 256; k++) begin
      m256[k] = 9'h000;
      m200[k] = 9'h000;
    end
    test_reset();
    test_write_read();
    test_back_to_back();
    test_clr();
    test_depth();
    test_rst_mid();
`ifdef DMEM_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/dmem_sweep_ram.md
# dmem_sweep_ram

Parametrised data memory, successor to the 256x9 data store: one write port, two registered read ports with write-through bypass, and a sequential clear engine that initialises the array by sweeping one word per cycle, so the array can map to block RAM. Sits between the processor datapath (load/store unit) and the memory-mapped load/store address space; `busy` stalls the pipeline while a sweep is in progress.

## Interface
- `DATA_W`, 9: word width.
- `ADDR_W`, 8: address width.
- `DEPTH`, 256: number of words; 2 ≤ DEPTH ≤ 2^ADDR_W.
- `INIT_VAL`, 0: value written by the sweep, DATA_W bits.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clr`  in  1  synchronous clear request; sampled only in IDLE.
- `we`  in  1  write enable.
- `wa`  in  ADDR_W  write address.
- `wd`  in  DATA_W  write data.
- `ra0`, `ra1`  in  ADDR_W  read addresses.
- `rd0`, `rd1`  out  DATA_W  registered read data.
- `busy`  out  1  sweep in progress.
- `clr_done`  out  1  one-cycle pulse on the last sweep write.
- `perr0`, `perr1`  out  1  parity error on the matching read port.

## Operation
- Two-state FSM: SWEEP, IDLE. Sweep counter `sa` is ADDR_W bits.
- `rst` asserted: state = SWEEP, `sa` = 0, `rd0`/`rd1` = 0, `busy` = 1, `clr_done` = 0, `perr*` = 0. Array contents are not touched by `rst`.
- SWEEP: each cycle writes INIT_VAL to `mem[sa]` and increments `sa`. When `sa` = DEPTH-1: write, pulse `clr_done`, go to IDLE, `sa` → 0.
- IDLE: `clr`=1 → SWEEP next cycle, `sa` = 0. Otherwise `we`=1 with `wa` < DEPTH writes `wd` to `mem[wa]`.
- During SWEEP: `we` and `clr` are ignored (write dropped, not queued), and both read ports return INIT_VAL.
- Reads in IDLE: `rdN` ← `mem[raN]` on the next edge.
  - If `we`=1 and `raN` == `wa` in the same cycle, return `wd` (write-through).
  - `raN` ≥ DEPTH returns 0.
- `wa` ≥ DEPTH: write dropped silently.
- `rst` asserted mid-sweep or mid-write: the sweep restarts from address 0.

## Timing
- Read latency: 1 cycle, address at edge N → data valid after edge N+1.
- Write visible to a read issued in the same cycle (bypass) and to all later reads.
- Sweep duration: DEPTH cycles from the first SWEEP cycle; `busy` is high for exactly DEPTH cycles after `rst` deassertion, or after `clr` is accepted.
- `busy` falls on the edge after the `clr_done` pulse.

## Configuration
- `DMEM_PARITY_EN` defined:
  - Each word stores an extra even-parity bit, computed on write and set correctly for INIT_VAL during the sweep.
  - `perrN` is registered alongside `rdN` and is 1 when the stored parity mismatches.
  - Bypassed reads always give `perrN`=0.
- `DMEM_PARITY_EN` undefined: no parity storage; `perr0`/`perr1` tied to 0.

## Structure
- Package `dmem_pkg`: FSM state enum (`DMEM_SWEEP`, `DMEM_IDLE`) and the parity function.
- Sub-module `dmem_sweep_ctl`: FSM plus sweep counter. Outputs `busy`, `clr_done`, the sweep address, and the sweep write strobe.
- The top level owns the array, the write mux (sweep vs. user), and the read ports.

## Test plan
- Release `rst` → `busy`=1 for 256 cycles, `clr_done` pulses once at cycle 256; reads of addresses 0, 100, 255 return 0.
- IDLE: write 0x1A5 to address 7, read address 7 next cycle → `rd0`=0x1A5. Same-cycle read of address 7 on `ra1` during the write → `rd1`=0x1A5.
- Write 0x0FF to address 3, pulse `clr` → `busy` goes high; `we` to address 3 with 0x111 during the sweep is ignored; after done, reading address 3 → 0.
- Assert `rst` at sweep cycle 120 → after release, `busy` lasts the full 256 cycles again.
- DEPTH=200: write to address 210 is dropped, read of 210 → 0, sweep lasts 200 cycles.
- With `DMEM_PARITY_EN`: force-flip a stored bit at address 5 → read of 5 gives `perr0`=1; reads of untouched addresses give `perr0`=0.
